// File: rtl/cnf_sweep_eval.sv
// cnf_sweep_eval: evaluates a product-of-sums Boolean function F over N_IN
// inputs. The live result y is F(x_in) registered with one cycle of latency.
// A start request sweeps every minterm over a snapshot of the masks and
// builds the truth vector tt_out and the minterm count ones_cnt.
// Latency: y is one cycle behind x_in; a sweep takes 2**N_IN busy cycles
// followed by a single done cycle.
// Backpressure: none; start is only accepted in IDLE and ignored otherwise.
// Optional feature: define CNF_TRISTATE_OUT_EN to make f high-impedance when
// en=0. When it is undefined, f is driven 0 when en=0 and the block contains
// no tri-state logic.
module cnf_sweep_eval #(
  parameter int N_IN     = 4,
  parameter int N_CLAUSE = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_IN-1:0]            x_in,
  input  logic [N_IN*N_CLAUSE-1:0]   pos_mask,
  input  logic [N_IN*N_CLAUSE-1:0]   neg_mask,
  input  logic [N_CLAUSE-1:0]        clause_en,
  input  logic                       start,
  input  logic                       en,
  output logic                       y,
  output logic                       f,
  output logic                       busy,
  output logic                       done,
  output logic [N_IN-1:0]            sweep_idx,
  output logic [(1<<N_IN)-1:0]       tt_out,
  output logic [N_IN:0]              ones_cnt
);

  localparam int              N_MINT   = 1 << N_IN;
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // A disabled clause is transparent (1). An enabled clause whose masks are
  // all zero has no literals, so its OR is 0 and it forces F to 0.
  function automatic logic cnf_eval(
    input logic [N_IN-1:0]          x,
    input logic [N_IN*N_CLAUSE-1:0] pm,
    input logic [N_IN*N_CLAUSE-1:0] nm,
    input logic [N_CLAUSE-1:0]      ce
  );
    logic acc;
    acc = 1'b1;
    for (int k = 0; k < N_CLAUSE; k++) begin
      if (ce[k] && (((pm[k*N_IN +: N_IN] & x) | (nm[k*N_IN +: N_IN] & ~x)) == '0)) begin
        acc = 1'b0;
      end
    end
    return acc;
  endfunction

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       w_capture;
  logic                       w_step;
  logic                       r_y;
  logic [N_IN*N_CLAUSE-1:0]   r_pos_snap;
  logic [N_IN*N_CLAUSE-1:0]   r_neg_snap;
  logic [N_CLAUSE-1:0]        r_cen_snap;
  logic [N_IN-1:0]            r_idx;
  logic [N_MINT-1:0]          r_tt;
  logic [N_IN:0]              r_ones;
  logic                       w_f_live;
  logic                       w_f_sweep;

  assign w_f_live  = cnf_eval(x_in, pos_mask, neg_mask, clause_en);
  assign w_f_sweep = cnf_eval(r_idx, r_pos_snap, r_neg_snap, r_cen_snap);

  // State register; reset aborts any sweep without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: accept start only in IDLE; leave SWEEP after the last index.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SWEEP;
        end
      end
      S_SWEEP: begin
        w_step = 1'b1;
        if (r_idx == IDX_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Live result path, independent of any sweep activity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y <= 1'b0;
    end else begin
      r_y <= w_f_live;
    end
  end

  // Snapshot of the function definition taken when a sweep is accepted, so
  // later mask changes cannot disturb the truth vector being built.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pos_snap <= '0;
      r_neg_snap <= '0;
      r_cen_snap <= '0;
    end else if (w_capture) begin
      r_pos_snap <= pos_mask;
      r_neg_snap <= neg_mask;
      r_cen_snap <= clause_en;
    end
  end

  // Sweep datapath: one minterm per cycle; index saturates at the last one
  // and results hold until the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_tt   <= '0;
      r_ones <= '0;
    end else if (w_capture) begin
      r_idx  <= '0;
      r_tt   <= '0;
      r_ones <= '0;
    end else if (w_step) begin
      r_tt[r_idx] <= w_f_sweep;
      r_ones      <= r_ones + {{N_IN{1'b0}}, w_f_sweep};
      if (r_idx != IDX_LAST) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign y         = r_y;
  assign busy      = (r_state == S_SWEEP);
  assign done      = (r_state == S_DONE);
  assign sweep_idx = r_idx;
  assign tt_out    = r_tt;
  assign ones_cnt  = r_ones;

`ifdef CNF_TRISTATE_OUT_EN
  assign f = en ? r_y : 1'bz;
`else
  assign f = en & r_y;
`endif

endmodule

// File: doc/cnf_sweep_eval.md
CNF_SWEEP_EVAL -- requirements
Module: cnf_sweep_eval

Interface
- REQ-001 The block SHALL have parameter N_IN, default 4, number of Boolean inputs, legal range 2..8.
- REQ-002 The block SHALL have parameter N_CLAUSE, default 3, number of OR-clauses (disterms), legal range 1..8.
- REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
- REQ-005 The block SHALL have port x_in, input, N_IN bits: live input vector.
- REQ-006 The block SHALL have port pos_mask, input, N_IN*N_CLAUSE bits: clause k uses bits [k*N_IN +: N_IN]; a set bit includes x[i] in clause k.
- REQ-007 The block SHALL have port neg_mask, input, N_IN*N_CLAUSE bits: same layout; a set bit includes ~x[i] in clause k.
- REQ-008 The block SHALL have port clause_en, input, N_CLAUSE bits: per-clause enable.
- REQ-009 The block SHALL have port start, input, 1 bit: sweep request.
- REQ-010 The block SHALL have port en, input, 1 bit: output-buffer enable.
- REQ-011 The block SHALL have port y, output, 1 bit: registered live result.
- REQ-012 The block SHALL have port f, output, 1 bit: buffered copy of y (see Configuration).
- REQ-013 The block SHALL have port busy, output, 1 bit: sweep in progress.
- REQ-014 The block SHALL have port done, output, 1 bit: one-cycle sweep-complete pulse.
- REQ-015 The block SHALL have port sweep_idx, output, N_IN bits: index currently evaluated.
- REQ-016 The block SHALL have port tt_out, output, 2**N_IN bits: truth vector, bit j = F(j).
- REQ-017 The block SHALL have port ones_cnt, output, N_IN+1 bits: count of minterms where F=1.

Function
- REQ-018 Clause k SHALL evaluate OR over i of (pos[k][i] & x[i]) | (neg[k][i] & ~x[i]); an enabled clause with all-zero masks SHALL evaluate 0.
- REQ-019 A disabled clause (clause_en[k]=0) SHALL evaluate 1; F SHALL be the AND of all clauses, so F=1 when every clause is disabled.
- REQ-020 y SHALL equal F(x_in) with exactly one cycle of latency in every state; it is not affected by sweeps.
- REQ-021 FSM states SHALL be IDLE, SWEEP and DONE.
- REQ-022 In IDLE with start=1: capture pos_mask, neg_mask and clause_en into snapshot registers, clear tt_out and ones_cnt, set sweep_idx=0, and go to SWEEP.
- REQ-023 In SWEEP, each cycle SHALL evaluate F(sweep_idx) on the snapshot, write tt_out[sweep_idx], add the result to ones_cnt, and increment sweep_idx.
- REQ-024 After index 2**N_IN-1 is evaluated, the FSM SHALL go to DONE, and sweep_idx SHALL hold at 2**N_IN-1 (no wrap).
- REQ-025 DONE SHALL last exactly one cycle with done=1 and then return to IDLE.
- REQ-026 busy SHALL be 1 exactly in SWEEP, for 2**N_IN cycles.
- REQ-027 start SHALL be ignored in SWEEP and DONE.
- REQ-028 start held high continuously SHALL begin a new sweep on the first IDLE cycle after DONE.
- REQ-029 Mask or clause_en changes during SWEEP SHALL NOT affect tt_out or ones_cnt.
- REQ-030 tt_out and ones_cnt SHALL hold their final values from DONE until the next accepted start.
- REQ-031 ones_cnt SHALL reach 2**N_IN without overflow when F is always 1.

Reset
- REQ-032 While rst_n=0 at a clock edge: FSM=IDLE, y=0, busy=0, done=0, sweep_idx=0, tt_out=0, ones_cnt=0, snapshot registers=0.
- REQ-033 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; start sampled in the same cycle SHALL be ignored.

Configuration
- REQ-034 With macro CNF_TRISTATE_OUT_EN defined, f SHALL equal y when en=1 and high-impedance when en=0.
- REQ-035 With CNF_TRISTATE_OUT_EN undefined, f SHALL equal y when en=1 and be driven 0 when en=0; the block SHALL contain no tri-state logic.

Verification
- REQ-036 Defaults, clauses (x3|x2|x0)(x2|~x1|~x0)(~x3|~x0), start pulse -> busy high 16 cycles, then done pulse, tt_out=16'h55F2, ones_cnt=9.
- REQ-037 Same masks, x_in stepped 0..15 with en=1 -> y follows tt_out bits with one-cycle lag; en=0 -> f=Z (macro defined) or 0 (macro undefined).
- REQ-038 clause_en=3'b000 plus sweep -> tt_out=16'hFFFF, ones_cnt=16; clause 0 enabled with zero masks -> tt_out=0, ones_cnt=0.
- REQ-039 Masks changed and start re-pulsed at SWEEP cycle 5 -> results still 16'h55F2/9, and no second sweep begins.
- REQ-040 rst_n low at SWEEP cycle 8 -> next cycle IDLE with all outputs 0 and no done pulse; a new start then gives 16'h55F2/9.
